// File: rtl/riscv_pkg.sv
// Shared RISC-V load/store definitions.
//   F3_*      : funct3 width/sign codes (instruction bits [14:12])
//   FC_*      : sticky fault cause encodings
//   mem_req_t : one data-memory access request
package riscv_pkg;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] FC_NONE     = 2'b00;
  localparam logic [1:0] FC_MISALIGN = 2'b01;
  localparam logic [1:0] FC_RANGE    = 2'b10;
  localparam logic [1:0] FC_FUNCT3   = 2'b11;

  typedef struct packed {
    logic        we;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mem_req_t;
endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering for one 32-bit data-memory access (combinational).
//   we, funct3, lane : access kind and byte offset addr[1:0]
//   wdata            : store data (low byte/half/word used)
//   rword            : raw word read from the array
//   be, wdata_rep    : per-lane byte enables and lane-replicated store data
//   ldata            : load result shifted to bit 0 and extended
//   misalign, illegal: alignment error / unsupported funct3 for this direction
module mem_lane_align
  import riscv_pkg::*;
(
  input  logic        we,
  input  logic [2:0]  funct3,
  input  logic [1:0]  lane,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  output logic [31:0] ldata,
  output logic        misalign,
  output logic        illegal
);
  logic [31:0] shifted;
  logic        sext;

  assign shifted = rword >> {lane, 3'b000};
  // funct3[2] marks the unsigned variants
  assign sext    = ~funct3[2];

  always_comb begin
    be        = 4'b0000;
    wdata_rep = wdata;
    ldata     = 32'h0;
    misalign  = 1'b0;
    illegal   = 1'b0;
    case (funct3)
      F3_B, F3_BU: begin
        be        = 4'b0001 << lane;
        wdata_rep = {4{wdata[7:0]}};
        ldata     = {{24{shifted[7] & sext}}, shifted[7:0]};
        illegal   = we & funct3[2];  // no unsigned stores
      end
      F3_H, F3_HU: begin
        be        = 4'b0011 << lane;
        wdata_rep = {2{wdata[15:0]}};
        ldata     = {{16{shifted[15] & sext}}, shifted[15:0]};
        misalign  = lane[0];
        illegal   = we & funct3[2];
      end
      F3_W: begin
        be       = 4'b1111;
        ldata    = rword;
        misalign = |lane;
      end
      default: illegal = 1'b1;
    endcase
  end
endmodule

// File: rtl/data_memory_bytelane.sv
// Byte-addressed data memory with per-lane enables, load extension,
// optional registered read and sticky first-fault capture.
//   clk, reset (async, active low)
//   req, we, funct3, addr, wdata : access request
//   rdata, rvalid                : load result (comb. or one-cycle latency)
//   fault, fault_cause, fault_addr, fault_clr : sticky first-fault status
module data_memory_bytelane
  import riscv_pkg::*;
#(
  parameter int DEPTH        = 1024,
  parameter int READ_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        rvalid,
  output logic        fault,
  output logic [1:0]  fault_cause,
  output logic [31:0] fault_addr,
  input  logic        fault_clr
);
  localparam int AW = $clog2(DEPTH);

  mem_req_t        rq;
  logic [AW-1:0]   widx;
  logic            out_of_range, misalign, illegal, err, load, wr_en;
  logic [3:0]      be;
  logic [31:0]     wdata_rep, ldata, load_data;
  logic [3:0][7:0] rword;
  logic [1:0]      cause;

  assign rq   = '{we: we, funct3: funct3, addr: addr, wdata: wdata};
  assign widx = rq.addr[AW+1:2];
  // Any set bit above the array span is out of range; addresses never wrap.
  assign out_of_range = |rq.addr[31:AW+2];

  mem_lane_align u_align (
    .we       (rq.we),
    .funct3   (rq.funct3),
    .lane     (rq.addr[1:0]),
    .wdata    (rq.wdata),
    .rword    (rword),
    .be       (be),
    .wdata_rep(wdata_rep),
    .ldata    (ldata),
    .misalign (misalign),
    .illegal  (illegal)
  );

  assign err   = illegal | out_of_range | misalign;
  assign cause = illegal      ? FC_FUNCT3 :
                 out_of_range ? FC_RANGE  :
                 misalign     ? FC_MISALIGN : FC_NONE;
  assign load      = req & ~rq.we;
  assign wr_en     = req & rq.we & ~err;
  assign load_data = err ? 32'h0 : ldata;

  // One storage array per byte lane so each lane has an independent write.
  for (genvar l = 0; l < 4; l++) begin : g_lane
    logic [7:0] lane_mem [DEPTH];
    always_ff @(posedge clk)
      if (wr_en && be[l]) lane_mem[widx] <= wdata_rep[8*l +: 8];
    assign rword[l] = lane_mem[widx];
  end

  if (READ_LATENCY == 0) begin : g_comb_rd
    assign rdata  = reset ? load_data : 32'h0;
    assign rvalid = reset & load;
  end else begin : g_reg_rd
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        rdata  <= 32'h0;
        rvalid <= 1'b0;
      end else begin
        rvalid <= load;
        if (load) rdata <= load_data;
      end
    end
  end

  // A new fault outranks a same-cycle clear; otherwise the first fault sticks.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fault       <= 1'b0;
      fault_cause <= FC_NONE;
      fault_addr  <= 32'h0;
    end else if (req && err && (!fault || fault_clr)) begin
      fault       <= 1'b1;
      fault_cause <= cause;
      fault_addr  <= rq.addr;
    end else if (fault_clr) begin
      fault       <= 1'b0;
      fault_cause <= FC_NONE;
      fault_addr  <= 32'h0;
    end
  end
endmodule

// File: tb/tb_data_memory_bytelane.sv
module tb_data_memory_bytelane;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req = 1'b0, we = 1'b0, fault_clr = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic [31:0] addr = 32'h0, wdata = 32'h0;
  logic [31:0] rdata1, rdata0, faddr1, faddr0;
  logic        rvalid1, rvalid0, fault1, fault0;
  logic [1:0]  cause1, cause0;
  logic [31:0] c_rdata0;
  logic        c_rvalid0;
  int          total = 0, passed = 0;

  always #5 clk = ~clk;

  data_memory_bytelane #(.DEPTH(1024), .READ_LATENCY(1)) dut1 (
    .clk(clk), .reset(reset), .req(req), .we(we), .funct3(funct3), .addr(addr),
    .wdata(wdata), .rdata(rdata1), .rvalid(rvalid1), .fault(fault1),
    .fault_cause(cause1), .fault_addr(faddr1), .fault_clr(fault_clr));

  data_memory_bytelane #(.DEPTH(1024), .READ_LATENCY(0)) dut0 (
    .clk(clk), .reset(reset), .req(req), .we(we), .funct3(funct3), .addr(addr),
    .wdata(wdata), .rdata(rdata0), .rvalid(rvalid0), .fault(fault0),
    .fault_cause(cause0), .fault_addr(faddr0), .fault_clr(fault_clr));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // One-cycle request: driven at negedge, combinational result snapshotted,
  // returns just after the capturing edge.
  task automatic op(input logic w, input logic [2:0] f, input logic [31:0] a,
                    input logic [31:0] d);
    @(negedge clk);
    req = 1'b1; we = w; funct3 = f; addr = a; wdata = d;
    #1;
    c_rdata0 = rdata0; c_rvalid0 = rvalid0;
    @(posedge clk); #1;
    req = 1'b0; we = 1'b0;
  endtask

  task automatic pulse_clr();
    @(negedge clk); fault_clr = 1'b1;
    @(posedge clk); #1; fault_clr = 1'b0;
  endtask

  typedef struct {
    logic        w;
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] exp;
  } vec_t;
  vec_t tv[15];

  initial begin
    tv[0]  = '{1'b1, 3'b010, 32'h10,  32'h8765_4321, 32'h0};
    tv[1]  = '{1'b0, 3'b010, 32'h10,  32'h0,         32'h8765_4321};
    tv[2]  = '{1'b1, 3'b000, 32'h12,  32'h0000_00AA, 32'h0};
    tv[3]  = '{1'b0, 3'b010, 32'h10,  32'h0,         32'h87AA_4321};
    tv[4]  = '{1'b0, 3'b000, 32'h12,  32'h0,         32'hFFFF_FFAA};
    tv[5]  = '{1'b0, 3'b100, 32'h12,  32'h0,         32'h0000_00AA};
    tv[6]  = '{1'b0, 3'b001, 32'h12,  32'h0,         32'hFFFF_87AA};
    tv[7]  = '{1'b0, 3'b101, 32'h12,  32'h0,         32'h0000_87AA};
    tv[8]  = '{1'b0, 3'b000, 32'h13,  32'h0,         32'hFFFF_FF87};
    tv[9]  = '{1'b1, 3'b001, 32'h16,  32'h0000_BEEF, 32'h0};
    tv[10] = '{1'b0, 3'b101, 32'h16,  32'h0,         32'h0000_BEEF};
    tv[11] = '{1'b0, 3'b001, 32'h16,  32'h0,         32'hFFFF_BEEF};
    tv[12] = '{1'b1, 3'b010, 32'hFFC, 32'hCAFE_F00D, 32'h0};
    tv[13] = '{1'b0, 3'b010, 32'hFFC, 32'h0,         32'hCAFE_F00D};
    tv[14] = '{1'b0, 3'b100, 32'hFFF, 32'h0,         32'h0000_00CA};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst rdata1", rdata1, 32'h0);
    chk("rst rvalid1", {31'h0, rvalid1}, 32'h0);
    chk("rst fault", {31'h0, fault1}, 32'h0);
    chk("rst cause", {30'h0, cause1}, 32'h0);
    chk("rst faddr", faddr1, 32'h0);
    chk("rst rdata0", rdata0, 32'h0);
    @(negedge clk); reset = 1'b1;

    // Store/load vectors against both read latencies
    foreach (tv[i]) begin
      op(tv[i].w, tv[i].f, tv[i].a, tv[i].d);
      if (tv[i].w) begin
        chk($sformatf("v%0d st rvalid1", i), {31'h0, rvalid1}, 32'h0);
        chk($sformatf("v%0d st rvalid0", i), {31'h0, c_rvalid0}, 32'h0);
      end else begin
        chk($sformatf("v%0d rdata1", i), rdata1, tv[i].exp);
        chk($sformatf("v%0d rvalid1", i), {31'h0, rvalid1}, 32'h1);
        chk($sformatf("v%0d rdata0", i), c_rdata0, tv[i].exp);
        chk($sformatf("v%0d rvalid0", i), {31'h0, c_rvalid0}, 32'h1);
      end
    end
    chk("no fault after vectors", {31'h0, fault1}, 32'h0);

    // Misaligned store: first fault sticks, nothing written
    op(1'b1, 3'b010, 32'h11, 32'h1111_1111);
    chk("mis fault", {31'h0, fault1}, 32'h1);
    chk("mis cause", {30'h0, cause1}, 32'h1);
    chk("mis faddr", faddr1, 32'h11);
    op(1'b0, 3'b010, 32'h10, 32'h0);
    chk("mis no write", rdata1, 32'h87AA_4321);
    op(1'b0, 3'b001, 32'h13, 32'h0);
    chk("LH13 rdata", rdata1, 32'h0);
    chk("LH13 rvalid", {31'h0, rvalid1}, 32'h1);
    chk("sticky faddr", faddr1, 32'h11);
    chk("sticky cause", {30'h0, cause1}, 32'h1);

    // Range fault, then clear-with-fault (set wins)
    pulse_clr();
    chk("clr fault", {31'h0, fault1}, 32'h0);
    chk("clr faddr", faddr1, 32'h0);
    op(1'b0, 3'b010, 32'h1000, 32'h0);
    chk("range rdata", rdata1, 32'h0);
    chk("range cause", {30'h0, cause1}, 32'h2);
    chk("range faddr", faddr1, 32'h1000);
    @(negedge clk);
    fault_clr = 1'b1; req = 1'b1; we = 1'b1; funct3 = 3'b100; addr = 32'h20; wdata = 32'h5;
    @(posedge clk); #1;
    fault_clr = 1'b0; req = 1'b0; we = 1'b0;
    chk("setwins fault", {31'h0, fault1}, 32'h1);
    chk("setwins cause", {30'h0, cause1}, 32'h3);
    chk("setwins faddr", faddr1, 32'h20);
    pulse_clr();
    op(1'b0, 3'b010, 32'h8000_0010, 32'h0);
    chk("highbit cause", {30'h0, cause1}, 32'h2);
    chk("highbit rdata", rdata1, 32'h0);
    pulse_clr();
    op(1'b0, 3'b111, 32'h10, 32'h0);
    chk("f3 111 cause", {30'h0, cause1}, 32'h3);

    // Reset in the middle of a registered read
    op(1'b0, 3'b010, 32'h10, 32'h0);
    chk("pre-rst rvalid", {31'h0, rvalid1}, 32'h1);
    #2 reset = 1'b0;
    #1;
    chk("midrst rvalid", {31'h0, rvalid1}, 32'h0);
    chk("midrst rdata", rdata1, 32'h0);
    chk("midrst fault", {31'h0, fault1}, 32'h0);
    @(negedge clk); reset = 1'b1;
    op(1'b0, 3'b010, 32'h10, 32'h0);
    chk("post-rst data", rdata1, 32'h87AA_4321);

    // Combinational read: store then load next cycle
    @(negedge clk);
    req = 1'b1; we = 1'b1; funct3 = 3'b010; addr = 32'h20; wdata = 32'h1;
    #1 chk("L0 store rvalid0", {31'h0, rvalid0}, 32'h0);
    @(posedge clk); #1;
    we = 1'b0;
    #1;
    chk("L0 next rdata0", rdata0, 32'h1);
    chk("L0 next rvalid0", {31'h0, rvalid0}, 32'h1);
    @(posedge clk); #1;
    req = 1'b0;
    chk("L1 b2b rdata1", rdata1, 32'h1);
    chk("L1 b2b rvalid1", {31'h0, rvalid1}, 32'h1);
    @(posedge clk); #1;
    chk("L1 idle rvalid", {31'h0, rvalid1}, 32'h0);
    chk("L1 idle hold", rdata1, 32'h1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/data_memory_bytelane.md
Name: data_memory_bytelane

Overview:
- Parametrised successor data memory for the RISC-V core; sits between the ALU/address path and the writeback mux.
- Byte-addressed; supports SB/SH/SW and LB/LH/LW/LBU/LHU through per-lane byte enables and load sign/zero extension.
- Selectable combinational or registered read.
- Detects misaligned, out-of-range and illegal-width accesses, and records the first fault in sticky status registers.

Parameters:
- DEPTH, 1024, number of 32-bit words (power of 2, ≥4); addressable bytes = DEPTH*4.
- READ_LATENCY, 1, 0 = combinational read, 1 = registered read (one cycle).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- req  in  1  access request this cycle.
- we  in  1  1 = store, 0 = load; qualified by req.
- funct3  in  3  RV32I width/sign code from instruction bits [14:12].
- addr  in  32  byte address.
- wdata  in  32  store data; the low byte/half/word is used.
- rdata  out  32  load result, already extended.
- rvalid  out  1  rdata valid.
- fault  out  1  sticky fault flag.
- fault_cause  out  2  01 misaligned, 10 out-of-range, 11 illegal funct3.
- fault_addr  out  32  address of the first faulting access.
- fault_clr  in  1  one-cycle pulse that clears the sticky fault.

Behaviour:
- Reset (reset=0, async): rdata=0, rvalid=0, fault=0, fault_cause=0, fault_addr=0. Any pending registered read is dropped. Memory array contents are not cleared. With READ_LATENCY=0, rdata is forced to 0 while reset=0.
- Word index = addr[AW+1:2], where AW = log2(DEPTH). Lane = addr[1:0].
- Legal funct3 values:
  - 000 LB/SB, 001 LH/SH, 010 LW/SW (loads and stores).
  - 100 LBU, 101 LHU (loads only).
- Access error (err), checked in priority order:
  - illegal funct3, which includes we=1 with 100/101: cause 11.
  - address ≥ DEPTH*4: cause 10.
  - half access with addr[0]=1, or word access with addr[1:0]≠0: cause 01.
- Store (req & we & ~err):
  - Byte enables: SB = 1<<lane; SH = 0011<<lane; SW = 1111.
  - Write data is replicated across lanes (byte ×4, half ×2).
  - Enabled lanes are written on the rising clk edge. Disabled lanes are unchanged.
  - A faulting store writes nothing.
- Load (req & ~we):
  - Selected byte or half is shifted to bit 0.
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
  - A faulting load returns rdata=0, with rvalid still asserted.
- READ_LATENCY=0:
  - rvalid = req & ~we, combinational.
  - rdata is combinational from the array.
  - A store at edge N is visible to a load in cycle N+1.
- READ_LATENCY=1:
  - At the edge where req & ~we, rdata/rvalid register the result; rvalid=1 for exactly the following cycle.
  - If there is no load at an edge, rvalid drops to 0 and rdata holds its last value.
  - Same-cycle load and store to the same word is impossible (one port). Back-to-back store then load returns the new data.
- Sticky fault:
  - On an edge with req & err while fault=0: set fault=1 and capture fault_cause and fault_addr.
  - While fault=1, later faults are ignored (the first fault is kept).
  - fault_clr=1 clears all three at the edge. If a faulting req arrives in the same cycle, the new fault is captured (set wins).
- A req with we=1 never asserts rvalid.
- An address whose bits above AW+1 are non-zero is out-of-range, never wrapped.

Decomposition:
- Shared package (riscv_pkg):
  - funct3 constants F3_B/F3_H/F3_W/F3_BU/F3_HU.
  - fault cause codes FC_NONE/FC_MISALIGN/FC_RANGE/FC_FUNCT3.
- One combinational sub-module, mem_lane_align:
  - inputs funct3, addr[1:0], wdata, raw word.
  - outputs byte enables, replicated write data, extended load data, misalign/illegal flags.
- The top level holds the array, the range check, the read register and the fault registers.

Test Plan:
1. Reset and read: hold reset=0 → all outputs 0. Release reset; SW addr=0x10 wdata=0x8765_4321; LW 0x10 → rdata=0x8765_4321 (rvalid one cycle later when READ_LATENCY=1).
2. Byte lanes: after test 1, SB addr=0x12 wdata=0xAA. LW 0x10 → 0x87AA_4321. LB 0x12 → 0xFFFF_FFAA. LBU 0x12 → 0x0000_00AA. LH 0x12 → 0xFFFF_87AA. LHU 0x12 → 0x0000_87AA.
3. Misaligned store: SW addr=0x11 → fault=1, cause=01, fault_addr=0x11, and word 0x10 unchanged. A following LH addr=0x13 faults, but fault_addr stays 0x11.
4. Range and funct3 faults: pulse fault_clr. LW addr=DEPTH*4 (0x1000) → cause=10, rdata=0. Pulse fault_clr together with a store of funct3=100 → cause=11 captured (set wins).
5. Reset mid-read: READ_LATENCY=1, issue LW, then assert reset before the next edge → rvalid=0, rdata=0. After release, the stored data is still readable.
6. READ_LATENCY=0 instance: SW 0x20=0x1 then LW 0x20 in the next cycle → rdata=0x1 in that same cycle with rvalid=1. Store-only cycles keep rvalid=0.
